// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch (I) and load/store (D) ports
//
// Purpose:
//   Grants one transaction at a time to either the fetch or the data port and
//   forwards it to a single-port memory.  D wins ties unless I has been passed
//   over STARVE_MAX consecutive times, in which case I is forced through.
//   Every output is a register; state flow is IDLE -> BUSY_I|BUSY_D -> RESP -> IDLE.
//
// Ports:
//   ma_clk, ma_rst            clock, synchronous active-high reset
//   ma_i_ce                   arbitration enable (gates new grants only)
//   ma_i_req/ma_i_addr        fetch request, held until ma_o_i_ack
//   ma_o_i_ack/ma_o_i_rdata   one-cycle fetch completion and data
//   ma_d_req/we/addr/wdata    data request, held until ma_o_d_ack
//   ma_o_d_ack/ma_o_d_rdata   one-cycle data completion and load data (0 on stores)
//   ma_o_m_req/we/addr/wdata  memory request, held until ma_m_ack
//   ma_m_ack/ma_m_rdata       memory completion and read data
//   ma_o_busy                 high whenever the FSM is not in IDLE

module mem_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH_MEM = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  ma_clk,
  input  logic                  ma_rst,
  input  logic                  ma_i_ce,
  input  logic                  ma_i_req,
  input  logic [AWIDTH_MEM-1:0] ma_i_addr,
  output logic                  ma_o_i_ack,
  output logic [DWIDTH-1:0]     ma_o_i_rdata,
  input  logic                  ma_d_req,
  input  logic                  ma_d_we,
  input  logic [AWIDTH_MEM-1:0] ma_d_addr,
  input  logic [DWIDTH-1:0]     ma_d_wdata,
  output logic                  ma_o_d_ack,
  output logic [DWIDTH-1:0]     ma_o_d_rdata,
  output logic                  ma_o_m_req,
  output logic                  ma_o_m_we,
  output logic [AWIDTH_MEM-1:0] ma_o_m_addr,
  output logic [DWIDTH-1:0]     ma_o_m_wdata,
  input  logic                  ma_m_ack,
  input  logic [DWIDTH-1:0]     ma_m_rdata,
  output logic                  ma_o_busy
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    m_req_nxt, m_we_nxt;
  logic [AWIDTH_MEM-1:0]   m_addr_nxt;
  logic [DWIDTH-1:0]       m_wdata_nxt;
  logic                    i_ack_nxt, d_ack_nxt;
  logic [DWIDTH-1:0]       i_rdata_nxt, d_rdata_nxt;
  logic                    grant_i;

  // I wins when it is alone, or when D has starved it for STARVE_MAX grants.
  assign grant_i = ma_i_req && (!ma_d_req || (cnt == CNT_MAX));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    m_req_nxt   = ma_o_m_req;
    m_we_nxt    = ma_o_m_we;
    m_addr_nxt  = ma_o_m_addr;
    m_wdata_nxt = ma_o_m_wdata;
    i_ack_nxt   = ma_o_i_ack;
    d_ack_nxt   = ma_o_d_ack;
    i_rdata_nxt = ma_o_i_rdata;
    d_rdata_nxt = ma_o_d_rdata;

    case (state)
      S_IDLE: begin
        if (ma_i_ce && (ma_i_req || ma_d_req)) begin
          m_req_nxt = 1'b1;
          if (grant_i) begin
            state_nxt   = S_BUSY_I;
            m_we_nxt    = 1'b0;
            m_addr_nxt  = ma_i_addr;
            m_wdata_nxt = '0;
            cnt_nxt     = '0;
          end else begin
            state_nxt   = S_BUSY_D;
            m_we_nxt    = ma_d_we;
            m_addr_nxt  = ma_d_addr;
            m_wdata_nxt = ma_d_wdata;
            // Only D grants that bypass a waiting I count toward starvation.
            if (!ma_i_req)
              cnt_nxt = '0;
            else if (cnt != CNT_MAX)
              cnt_nxt = cnt + CW'(1);
          end
        end
      end

      S_BUSY_I: begin
        if (ma_m_ack) begin
          m_req_nxt   = 1'b0;
          m_we_nxt    = 1'b0;
          i_rdata_nxt = ma_m_rdata;
          i_ack_nxt   = 1'b1;
          state_nxt   = S_RESP;
        end
      end

      S_BUSY_D: begin
        if (ma_m_ack) begin
          m_req_nxt   = 1'b0;
          m_we_nxt    = 1'b0;
          d_rdata_nxt = ma_o_m_we ? '0 : ma_m_rdata;
          d_ack_nxt   = 1'b1;
          state_nxt   = S_RESP;
        end
      end

      S_RESP: begin
        i_ack_nxt   = 1'b0;
        d_ack_nxt   = 1'b0;
        i_rdata_nxt = '0;
        d_rdata_nxt = '0;
        state_nxt   = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ma_clk) begin
    if (ma_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ma_o_m_req   <= 1'b0;
      ma_o_m_we    <= 1'b0;
      ma_o_m_addr  <= '0;
      ma_o_m_wdata <= '0;
      ma_o_i_ack   <= 1'b0;
      ma_o_d_ack   <= 1'b0;
      ma_o_i_rdata <= '0;
      ma_o_d_rdata <= '0;
      ma_o_busy    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ma_o_m_req   <= m_req_nxt;
      ma_o_m_we    <= m_we_nxt;
      ma_o_m_addr  <= m_addr_nxt;
      ma_o_m_wdata <= m_wdata_nxt;
      ma_o_i_ack   <= i_ack_nxt;
      ma_o_d_ack   <= d_ack_nxt;
      ma_o_i_rdata <= i_rdata_nxt;
      ma_o_d_rdata <= d_rdata_nxt;
      // busy follows the state being entered so it stays a plain register.
      ma_o_busy    <= (state_nxt != S_IDLE);
    end
  end

endmodule
